// File: rtl/array_column_streamer.sv
// Streams one packed row of COLS elements out one column per valid/ready beat.
// Define ARRAY_STREAM_REVERSE_EN to emit columns from COLS-1 down to 0.
module array_column_streamer #(
    parameter int BIT_WIDTH = 4,
    parameter int COLS = 8,
    localparam int IDX_W = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [COLS*BIT_WIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BIT_WIDTH-1:0]      out_data,
    output logic [IDX_W-1:0]          out_col,
    output logic                      out_last,
    output logic                      busy
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(COLS - 1);

`ifdef ARRAY_STREAM_REVERSE_EN
    localparam logic [IDX_W-1:0] FIRST_IDX = TOP_IDX;
    localparam logic [IDX_W-1:0] FINAL_IDX = '0;
`else
    localparam logic [IDX_W-1:0] FIRST_IDX = '0;
    localparam logic [IDX_W-1:0] FINAL_IDX = TOP_IDX;
`endif

    logic [0:0]                 state;
    logic [COLS*BIT_WIDTH-1:0]  row;
    logic [IDX_W-1:0]           cnt;
    logic [IDX_W-1:0]           cnt_next;
    logic                       accept;
    logic                       xfer;

    assign out_valid = (state == STREAM);
    assign busy      = (state == STREAM);
    // Gated by state so reset leaves out_last low even when FINAL_IDX is 0.
    assign out_last  = (state == STREAM) && (cnt == FINAL_IDX);
    assign out_col   = cnt;
    assign xfer      = out_valid && out_ready;
    assign in_ready  = (state == IDLE) || (xfer && out_last);
    assign accept    = in_valid && in_ready;

`ifdef ARRAY_STREAM_REVERSE_EN
    assign cnt_next = cnt - IDX_W'(1);
`else
    assign cnt_next = cnt + IDX_W'(1);
`endif

    always_comb begin
        out_data = '0;
        for (int i = 0; i < COLS; i++) begin
            if (cnt == IDX_W'(i)) begin
                out_data = row[i*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            row   <= '0;
            cnt   <= '0;
        end else if (accept) begin
            state <= STREAM;
            row   <= in_data;
            cnt   <= FIRST_IDX;
        end else if (xfer) begin
            if (out_last) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt_next;
            end
        end
    end

endmodule

// File: tb/tb_array_column_streamer.sv
// Directed bench for array_column_streamer: an 8x4 instance and a 3x8 instance.
// Expected column order follows ARRAY_STREAM_REVERSE_EN when it is defined.
module tb_array_column_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [2:0]  out_col;
    logic        out_last;
    logic        busy;

    logic        v3 = 1'b0;
    logic [23:0] d3 = '0;
    logic        r3 = 1'b0;
    logic        ir3;
    logic        ov3;
    logic [7:0]  od3;
    logic [1:0]  oc3;
    logic        ol3;
    logic        b3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    array_column_streamer #(.BIT_WIDTH(4), .COLS(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_col(out_col), .out_last(out_last), .busy(busy)
    );

    array_column_streamer #(.BIT_WIDTH(8), .COLS(3)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(v3), .in_ready(ir3), .in_data(d3),
        .out_valid(ov3), .out_ready(r3), .out_data(od3),
        .out_col(oc3), .out_last(ol3), .busy(b3)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int col_of(input int j, input int n);
`ifdef ARRAY_STREAM_REVERSE_EN
        return n - 1 - j;
`else
        return j;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int xfers;
        int c;

        step();
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_col", out_col, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        rst = 1'b0;
        #1;
        check("rst_ready", in_ready, 1);
        check("rst_ready3", ir3, 1);
        step();

        // basic stream
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h76543210;
        check("basic_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        in_data = 32'hAAAAAAAA;
        for (int j = 0; j < 8; j++) begin
            c = col_of(j, 8);
            check("basic_valid", out_valid, 1);
            check("basic_busy", busy, 1);
            check("basic_data", out_data, c);
            check("basic_col", out_col, c);
            check("basic_last", out_last, (j == 7) ? 1 : 0);
            check("basic_in_ready", in_ready, (j == 7) ? 1 : 0);
            step();
        end
        check("basic_idle", out_valid, 0);
        check("basic_idle_busy", busy, 0);

        // backpressure: ready pattern 1,0,0,1 repeating
        in_valid = 1'b1;
        in_data = 32'h76543210;
        step();
        in_valid = 1'b0;
        xfers = 0;
        for (int cyc = 0; cyc < 40 && xfers < 8; cyc++) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            #1;
            c = col_of(xfers, 8);
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, c);
            check("bp_col", out_col, c);
            check("bp_last", out_last, (xfers == 7) ? 1 : 0);
            step();
            if (out_ready) xfers++;
        end
        check("bp_xfers", xfers, 8);
        check("bp_idle", out_valid, 0);
        out_ready = 1'b1;

        // back-to-back rows
        in_valid = 1'b1;
        in_data = 32'h76543210;
        step();
        in_data = 32'hFEDCBA98;
        for (int j = 0; j < 16; j++) begin
            c = (j < 8) ? col_of(j, 8) : 8 + col_of(j - 8, 8);
            check("b2b_valid", out_valid, 1);
            check("b2b_data", out_data, c % 8 + ((j < 8) ? 0 : 8));
            check("b2b_last", out_last, (j % 8 == 7) ? 1 : 0);
            check("b2b_in_ready", in_ready, (j % 8 == 7) ? 1 : 0);
            step();
            if (j == 7) in_valid = 1'b0;
        end
        check("b2b_idle", out_valid, 0);

        // reset mid-row after three transfers
        in_valid = 1'b1;
        in_data = 32'h76543210;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        check("mid_col3", out_col, col_of(3, 8));
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_col", out_col, 0);
        check("mid_rst_last", out_last, 0);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rel_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data = 32'h89ABCDEF;
        step();
        in_valid = 1'b0;
        c = col_of(0, 8);
        check("mid_new_valid", out_valid, 1);
        check("mid_new_col", out_col, c);
        check("mid_new_data", out_data, (32'h89ABCDEF >> (c * 4)) & 32'hF);
        for (int j = 0; j < 8; j++) step();
        check("mid_new_idle", out_valid, 0);

        // three-column instance
        r3 = 1'b1;
        v3 = 1'b1;
        d3 = 24'hCCBBAA;
        step();
        v3 = 1'b0;
        for (int j = 0; j < 3; j++) begin
            c = col_of(j, 3);
            check("c3_valid", ov3, 1);
            check("c3_col", oc3, c);
            check("c3_col_range", (oc3 < 2'd3) ? 1 : 0, 1);
            check("c3_data", od3, 8'hAA + c * 8'h11);
            check("c3_last", ol3, (j == 2) ? 1 : 0);
            step();
        end
        check("c3_idle", ov3, 0);
        check("c3_idle_busy", b3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
